// File: rtl/udma_spim_cmd_gen_pkg.sv
// Types and word builders for the uDMA SPI master command generator.
// Callers pass fields already zero-extended to their word slot width.
`include "udma_spim_defines.sv"

package udma_spim_cmd_gen_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_UCA,
        ST_UCS,
        ST_SOT,
        ST_CMD,
        ST_ADDR,
        ST_ADDR_RAW,
        ST_DUMMY,
        ST_DATA,
        ST_EOT
    } state_e;

    localparam int unsigned CMD_BITS  = 7;
    localparam int unsigned ADDR_BITS = 23;

    function automatic logic [31:0] word_uca(
        input logic        txrxn,
        input logic [26:0] buf_addr
    );
        return {`SPI_CMD_SETUP_UCA, txrxn, buf_addr};
    endfunction

    function automatic logic [31:0] word_ucs(
        input logic        txrxn,
        input logic [1:0]  ds,
        input logic [24:0] size
    );
        return {`SPI_CMD_SETUP_UCS, txrxn, ds, size};
    endfunction

    function automatic logic [31:0] word_sot(input logic [1:0] cs);
        return {`SPI_CMD_SOT, 26'd0, cs};
    endfunction

    function automatic logic [31:0] word_cmd(
        input logic       qpi,
        input logic [7:0] opcode
    );
        return {`SPI_CMD_SEND_CMD, qpi, 7'd0, 4'(CMD_BITS), 8'd0, opcode};
    endfunction

    function automatic logic [31:0] word_addr(input logic qpi);
        return {`SPI_CMD_SEND_ADDR, qpi, 6'd0, 5'(ADDR_BITS), 16'd0};
    endfunction

    function automatic logic [31:0] word_addr_raw(input logic [31:0] addr);
        return {8'h00, addr[23:0]};
    endfunction

    function automatic logic [31:0] word_dummy(input logic [4:0] dummy);
        return {`SPI_CMD_DUMMY, 7'd0, dummy - 5'd1, 16'd0};
    endfunction

    function automatic logic [31:0] word_data(
        input logic        txrxn,
        input logic        qpi,
        input logic [26:0] size_m1
    );
        logic [3:0] op;
        op = txrxn ? `SPI_CMD_TX_DATA : `SPI_CMD_RX_DATA;
        return {op, qpi, size_m1};
    endfunction

    function automatic logic [31:0] word_eot(input logic evt);
        return {`SPI_CMD_EOT, 27'd0, evt};
    endfunction

    // Skipped phases are resolved here so the FSM never visits them.
    function automatic state_e next_state(
        input state_e st,
        input logic   size_nz,
        input logic   addr_en,
        input logic   dummy_nz
    );
        state_e after_addr;
        after_addr = dummy_nz ? ST_DUMMY : (size_nz ? ST_DATA : ST_EOT);
        unique case (st)
            ST_IDLE:     return size_nz ? ST_UCA : ST_SOT;
            ST_UCA:      return ST_UCS;
            ST_UCS:      return ST_SOT;
            ST_SOT:      return ST_CMD;
            ST_CMD:      return addr_en ? ST_ADDR : after_addr;
            ST_ADDR:     return ST_ADDR_RAW;
            ST_ADDR_RAW: return after_addr;
            ST_DUMMY:    return size_nz ? ST_DATA : ST_EOT;
            ST_DATA:     return ST_EOT;
            default:     return ST_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/udma_spim_defines.sv
// uDMA SPI master command opcodes shared by the register interface,
// the controller and the hardware command generator.
`ifndef UDMA_SPIM_DEFINES_SV
`define UDMA_SPIM_DEFINES_SV

`define SPI_CMD_CFG       4'b0000
`define SPI_CMD_SOT       4'b0001
`define SPI_CMD_SEND_CMD  4'b0010
`define SPI_CMD_SEND_ADDR 4'b0011
`define SPI_CMD_DUMMY     4'b0100
`define SPI_CMD_WAIT      4'b0101
`define SPI_CMD_TX_DATA   4'b0110
`define SPI_CMD_RX_DATA   4'b0111
`define SPI_CMD_RPT       4'b1000
`define SPI_CMD_EOT       4'b1001
`define SPI_CMD_RPT_END   4'b1010
`define SPI_CMD_RX_CHECK  4'b1011
`define SPI_CMD_FULL_DUPL 4'b1100
`define SPI_CMD_SETUP_UCA 4'b1101
`define SPI_CMD_SETUP_UCS 4'b1110

`endif

// File: rtl/udma_spim_cmd_gen.sv
// Turns one flash transfer request into the uDMA SPI command word stream.
// state_q names the word currently presented on cmd_o.
module udma_spim_cmd_gen
    import udma_spim_cmd_gen_pkg::*;
#(
    parameter int unsigned L2_AWIDTH_NOAL = 12,
    parameter int unsigned TRANS_SIZE     = 16
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic                      clear_i,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic                      req_txrxn_i,
    input  logic [L2_AWIDTH_NOAL-1:0] req_buf_addr_i,
    input  logic [TRANS_SIZE-1:0]     req_size_i,
    input  logic [1:0]                req_ds_i,
    input  logic [1:0]                req_cs_i,
    input  logic                      req_qpi_i,
    input  logic [7:0]                req_opcode_i,
    input  logic                      req_addr_en_i,
    input  logic [31:0]               req_flash_addr_i,
    input  logic [4:0]                req_dummy_i,
    input  logic                      req_eot_evt_i,
    output logic [31:0]               cmd_o,
    output logic                      cmd_valid_o,
    input  logic                      cmd_ready_i,
    output logic                      busy_o,
    output logic                      done_o
);

    state_e                    state_q, state_d, nxt;
    logic [31:0]               cmd_q, cmd_d, word;
    logic                      cmd_valid_q, cmd_valid_d;
    logic                      done_q, done_d;

    logic                      txrxn_q;
    logic [L2_AWIDTH_NOAL-1:0] buf_addr_q;
    logic [TRANS_SIZE-1:0]     size_q;
    logic [1:0]                ds_q;
    logic [1:0]                cs_q;
    logic                      qpi_q;
    logic [7:0]                opcode_q;
    logic                      addr_en_q;
    logic [31:0]               flash_addr_q;
    logic [4:0]                dummy_q;
    logic                      eot_evt_q;

    logic                      capture, fire;
    logic                      sel_txrxn, sel_qpi, sel_addr_en, sel_evt;
    logic [L2_AWIDTH_NOAL-1:0] sel_buf_addr;
    logic [TRANS_SIZE-1:0]     sel_size, sel_size_m1;
    logic [1:0]                sel_ds, sel_cs;
    logic [7:0]                sel_opcode;
    logic [31:0]               sel_flash_addr;
    logic [4:0]                sel_dummy;

    assign capture = req_valid_i && (state_q == ST_IDLE);
    assign fire    = cmd_valid_q && cmd_ready_i;

    // The first word is built from the live request, later ones from the copy.
    always_comb begin
        sel_txrxn      = capture ? req_txrxn_i      : txrxn_q;
        sel_buf_addr   = capture ? req_buf_addr_i   : buf_addr_q;
        sel_size       = capture ? req_size_i       : size_q;
        sel_ds         = capture ? req_ds_i         : ds_q;
        sel_cs         = capture ? req_cs_i         : cs_q;
        sel_qpi        = capture ? req_qpi_i        : qpi_q;
        sel_opcode     = capture ? req_opcode_i     : opcode_q;
        sel_addr_en    = capture ? req_addr_en_i    : addr_en_q;
        sel_flash_addr = capture ? req_flash_addr_i : flash_addr_q;
        sel_dummy      = capture ? req_dummy_i      : dummy_q;
        sel_evt        = capture ? req_eot_evt_i    : eot_evt_q;
        sel_size_m1    = sel_size - TRANS_SIZE'(1);
    end

    always_comb begin
        nxt = next_state(capture ? ST_IDLE : state_q,
                         |sel_size, sel_addr_en, |sel_dummy);
        word = 32'd0;
        unique case (nxt)
            ST_UCA:      word = word_uca(sel_txrxn, 27'(sel_buf_addr));
            ST_UCS:      word = word_ucs(sel_txrxn, sel_ds, 25'(sel_size));
            ST_SOT:      word = word_sot(sel_cs);
            ST_CMD:      word = word_cmd(sel_qpi, sel_opcode);
            ST_ADDR:     word = word_addr(sel_qpi);
            ST_ADDR_RAW: word = word_addr_raw(sel_flash_addr);
            ST_DUMMY:    word = word_dummy(sel_dummy);
            ST_DATA:     word = word_data(sel_txrxn, sel_qpi,
                                          27'(sel_size_m1));
            ST_EOT:      word = word_eot(sel_evt);
            default:     word = 32'd0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        cmd_valid_d = cmd_valid_q;
        done_d      = 1'b0;
        if (clear_i) begin
            state_d     = ST_IDLE;
            cmd_d       = 32'd0;
            cmd_valid_d = 1'b0;
        end else if (capture || fire) begin
            state_d     = nxt;
            cmd_d       = word;
            cmd_valid_d = (nxt != ST_IDLE);
            done_d      = fire && (state_q == ST_EOT);
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q      <= ST_IDLE;
            cmd_q        <= 32'd0;
            cmd_valid_q  <= 1'b0;
            done_q       <= 1'b0;
            txrxn_q      <= 1'b0;
            buf_addr_q   <= '0;
            size_q       <= '0;
            ds_q         <= 2'd0;
            cs_q         <= 2'd0;
            qpi_q        <= 1'b0;
            opcode_q     <= 8'd0;
            addr_en_q    <= 1'b0;
            flash_addr_q <= 32'd0;
            dummy_q      <= 5'd0;
            eot_evt_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            cmd_valid_q <= cmd_valid_d;
            done_q      <= done_d;
            if (capture && !clear_i) begin
                txrxn_q      <= req_txrxn_i;
                buf_addr_q   <= req_buf_addr_i;
                size_q       <= req_size_i;
                ds_q         <= req_ds_i;
                cs_q         <= req_cs_i;
                qpi_q        <= req_qpi_i;
                opcode_q     <= req_opcode_i;
                addr_en_q    <= req_addr_en_i;
                flash_addr_q <= req_flash_addr_i;
                dummy_q      <= req_dummy_i;
                eot_evt_q    <= req_eot_evt_i;
            end
        end
    end

    assign cmd_o       = cmd_q;
    assign cmd_valid_o = cmd_valid_q;
    assign done_o      = done_q;
    assign busy_o      = (state_q != ST_IDLE);
    assign req_ready_o = (state_q == ST_IDLE);

endmodule

// File: doc/udma_spim_cmd_gen.md
# udma_spim_cmd_gen

Hardware command-stream producer for the uDMA SPI master. It accepts one high-level flash transfer request and emits the matching sequence of 32-bit SPI command words on the uDMA command channel. The channel's valid/ready handshake is the same one the SPI register interface and controller consume. The block lets a sequencer run flash reads and writes without software building command buffers in L2.

## Interface
Parameters:
- L2_AWIDTH_NOAL, 12: L2 buffer address width.
- TRANS_SIZE, 16: transfer size width, in bytes.

Ports:
- clk_i  in  1  clock.
- rstn_i  in  1  reset; asynchronous, active-low.
- clear_i  in  1  synchronous abort; forces IDLE.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request ready; high only in IDLE.
- req_txrxn_i  in  1  1 = write to flash (TX data), 0 = read (RX data).
- req_buf_addr_i  in  L2_AWIDTH_NOAL  L2 buffer start address.
- req_size_i  in  TRANS_SIZE  data bytes; 0 means no data phase.
- req_ds_i  in  2  uDMA datasize code.
- req_cs_i  in  2  chip select.
- req_qpi_i  in  1  quad mode for all phases.
- req_opcode_i  in  8  flash command byte.
- req_addr_en_i  in  1  include the address phase.
- req_flash_addr_i  in  32  flash address (24 LSBs are used).
- req_dummy_i  in  5  dummy cycles; 0 skips the dummy word.
- req_eot_evt_i  in  1  EOT word raises an event.
- cmd_o  out  32  command word.
- cmd_valid_o  out  1  command word valid.
- cmd_ready_i  in  1  downstream accepts.
- busy_o  out  1  high whenever state is not IDLE.
- done_o  out  1  one-cycle pulse after the EOT word is accepted.

## Operation
- Opcodes in cmd_o[31:28] use the SPI_CMD_* macros from udma_spim_defines.
- Word layouts (all unlisted bits are 0):
  - SETUP_UCA: [27]=txrxn, [L2_AWIDTH_NOAL-1:0]=buf_addr.
  - SETUP_UCS: [27]=txrxn, [26:25]=ds, [TRANS_SIZE-1:0]=size.
  - SOT: [1:0]=cs.
  - SEND_CMD: [27]=qpi, [19:16]=7, [7:0]=opcode.
  - SEND_ADDR: [27]=qpi, [20:16]=23. This word is always followed by a raw word {8'h00, flash_addr[23:0]}.
  - DUMMY: [20:16]=dummy-1.
  - TX_DATA / RX_DATA: [27]=qpi, [TRANS_SIZE-1:0]=size-1. The opcode is chosen by txrxn.
  - EOT: [0]=eot_evt.
- The request is captured on req_valid_i & req_ready_o. Inputs are don't-care afterwards.
- FSM states: IDLE, UCA, UCS, SOT, CMD, ADDR, ADDR_RAW, DUMMY, DATA, EOT.
- Sequence order:
  - UCA → UCS, only if size≠0.
  - SOT → CMD.
  - ADDR → ADDR_RAW, only if addr_en.
  - DUMMY, only if dummy≠0.
  - DATA, only if size≠0.
  - EOT → IDLE.
  - Skipped states are never entered.
- A state advances only on cmd_valid_o & cmd_ready_i.
- cmd_o and cmd_valid_o are registered. While valid is high, cmd_o is held stable until it is accepted.
- size-1 is computed in TRANS_SIZE bits. Size 0 never reaches it.
- clear_i has priority over everything, including a handshake in the same cycle. On the next edge: state=IDLE, cmd_valid_o=0, no done_o. A partially issued sequence is abandoned.

## Timing
- Reset values: cmd_o=0, cmd_valid_o=0, busy_o=0, done_o=0, state=IDLE, req_ready_o=1.
- Request accepted at edge N: cmd_valid_o=1 with the first word from cycle N+1.
- Each accepted word is replaced by the next word at the same edge. With cmd_ready_i held high, the block sustains one word per cycle with no bubbles.
- Full sequence length is 3 + 2·(size≠0) + 2·addr_en + (dummy≠0) + (size≠0) words, counting SOT, CMD and EOT as the 3.
- EOT accepted at edge M:
  - done_o=1 during cycle M+1.
  - busy_o=0 and req_ready_o=1 from cycle M+1.
  - A new request can be accepted at edge M+1.
- cmd_ready_i low stalls the block indefinitely. Valid stays high and the word does not change.
- An asynchronous reset mid-sequence immediately restores all reset values.

## Structure
- A new udma_spim_cmd_gen_pkg holds:
  - the state enum;
  - localparams for the bit-count fields (7, 23);
  - word-build functions, one per opcode.
- Opcode values stay in udma_spim_defines; they are not duplicated.
- The block is a single module with no sub-module. The FSM and output register are tightly coupled.

## Test plan
- Read with size 256, addr_en, dummy 8, QPI, cs 1, opcode 0xEB, buf_addr 0x100, cmd_ready_i=1:
  - expect 9 consecutive words: UCA(0x100), UCS(size 0x100, txrxn 0), SOT(1), CMD(0xEB, qpi), ADDR, raw addr, DUMMY(7), RX_DATA(0xFF), EOT;
  - then done_o pulse and busy_o low.
- Size 0, no addr, no dummy, opcode 0x06: exactly SOT, CMD, EOT; no UCA, UCS or DATA.
- Write with size 1, opcode 0x02: UCS carries txrxn=1; data word is TX_DATA with size field 0.
- Random cmd_ready_i backpressure (about 50%): cmd_o stable while valid and not ready; order unchanged; no word dropped or duplicated.
- clear_i asserted on the ADDR_RAW handshake cycle: next cycle valid=0, state IDLE, no done_o; a following request starts cleanly at UCA.
- Reset asserted mid-DATA: outputs return to reset values immediately; req_ready_o=1 after release.
